dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and access sequencer for the single-ported data memory. It shares the memory between requester 0 (pipeline load/store unit) and requester 1 (DMA/debug port). It accepts one request per grant and drives the memory's active-low chip-select/write strobes for exactly one cycle. It returns read data or a write acknowledge through a registered response pulse. Port 0 has fixed priority, bounded by a starvation counter that guarantees port 1 forward progress.

## Interface
Parameters:
- DEPTH, 1024: memory depth in 32-bit words; addresses >= DEPTH are out of range.
- STARVE_MAX, 4: consecutive port-0 grants, while port 1 waits, after which port 1 wins.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0 / req1  in  1  request from port 0 / port 1; held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  word address.
- wdata0 / wdata1  in  32  write data.
- mask0 / mask1  in  4  byte-enable, bit i = byte i; ignored on reads.
- gnt0 / gnt1  out  1  combinational accept; request is consumed at the rising edge where req & gnt.
- rvalid0 / rvalid1  out  1  one-cycle response pulse (read data or write ack).
- rdata0 / rdata1  out  32  read data, valid only with rvalid; 0 for writes and errors.
- err0 / err1  out  1  out-of-range flag, valid only with rvalid.
- dm_cs  out  1  memory chip select, active-low.
- dm_wr  out  1  memory write strobe, active-low; 0 = write, 1 = read.
- dm_addr  out  32  memory address.
- dm_mask  out  4  memory byte mask; 0 on reads.
- dm_wdata  out  32  memory write data.
- dm_rdata  in  32  asynchronous memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: accept a request, go to ACCESS. With no request, stay in IDLE.
  - ACCESS: always goes to RESP.
  - RESP: accept a request, go to ACCESS. Otherwise go to IDLE.
- gnt is asserted only in IDLE or RESP, to at most one port.
- Arbitration when both req are high: port 0 wins unless starve_cnt == STARVE_MAX, in which case port 1 wins.
- starve_cnt (3+ bits, saturating at STARVE_MAX):
  - +1 on each port-0 grant while req1 is high.
  - Cleared on a port-1 grant, or any accept cycle with req1 low.
- Accepted request is latched into owner, we, addr, wdata, mask registers.
- ACCESS with addr < DEPTH:
  - dm_cs = 0, dm_wr = ~we, dm_addr/dm_wdata from latches.
  - dm_mask = mask if write, 0 if read.
- ACCESS with addr >= DEPTH: dm_cs stays 1 (no memory access); error flag latched.
- Read data: dm_rdata is captured at the rising edge ending ACCESS (0 on error).
- RESP: the owner's rvalid = 1, with rdata and err from registers. The other port's rvalid = 0.
- A write with mask 4'b0000 performs a normal access cycle and ack, but changes no bytes.
- Outside ACCESS: dm_cs = 1, dm_wr = 1, dm_mask = 0. dm_addr/dm_wdata hold their latched values.

## Timing
- Reset values: state IDLE, starve_cnt 0, dm_cs 1, dm_wr 1, dm_mask 0, dm_addr 0, dm_wdata 0, rvalid0/1 0, rdata0/1 0, err0/1 0.
- Since dm_cs decodes from state, asserting rst during ACCESS deasserts dm_cs immediately. The memory's negedge write must not occur if rst rises before that negedge.
- Latency, accept at edge N:
  - Cycle N+1: ACCESS. The memory write lands on the falling edge inside this cycle.
  - Cycle N+2: RESP with rvalid.
- Throughput: one access per 2 cycles. Back-to-back accepts occur from RESP.
- A requester must not change addr/we/wdata/mask while req is high and gnt is low.
- req may drop without a grant. This has no effect, except that starve_cnt clears on the next accept cycle.
- A port may issue a new request in its own RESP cycle; it is arbitrated normally.

## Test plan
- Port-0 write addr 5, data 32'hDEADBEEF, mask 4'b1111.
  - Required: dm_cs = 0 and dm_wr = 0 for exactly one cycle; rvalid0 pulse 2 cycles after accept.
  - Follow-up read of addr 5: rdata0 = 32'hDEADBEEF.
- Write 32'h11223344 with mask 4'b0101 over 32'hAAAAAAAA, then read. Required: 32'hAA22AA44.
- req0 and req1 held high continuously, STARVE_MAX = 4. Required grant sequence: 0,0,0,0,1,0,0,0,0,1.
- Read addr 1024. Required: dm_cs stays 1, rvalid1 pulse with err1 = 1 and rdata1 = 0.
- rst asserted mid-ACCESS of a write to addr 7, before the falling edge.
  - Required: all outputs at reset values immediately; mem[7] unchanged.
  - Required: after release, a new request is served normally.
- Back-to-back reads from port 0, addresses 0,1,2. Required: rvalid0 every other cycle, correct data each time.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface dm_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  mask0, mask1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        dm_cs;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_mask;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1, dm_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           dm_cs, dm_wr, dm_addr, dm_mask, dm_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1, dm_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           dm_cs, dm_wr, dm_addr, dm_mask, dm_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory: fixed port-0 priority
// with a starvation limit, one-cycle memory strobe, registered response pulse.
module dm_arbiter #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int unsigned SW_RAW = $clog2(STARVE_MAX + 1);
  localparam int unsigned SW     = (SW_RAW > 3) ? SW_RAW : 3;
  localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH);

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic          owner;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic accept_state;
  logic gnt0, gnt1;
  logic oor;
  logic mem_access;

  assign accept_state = (state == IDLE) || (state == RESP);
  assign gnt1 = accept_state && bus.req1 && (!bus.req0 || (starve_cnt == SMAX));
  assign gnt0 = accept_state && bus.req0 && !gnt1;
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  assign oor        = (addr_q >= DEPTH_W);
  assign mem_access = (state == ACCESS) && !oor;

  // Strobes decode from state so an async reset during ACCESS drops them at once.
  assign bus.dm_cs    = !mem_access;
  assign bus.dm_wr    = !(mem_access && we_q);
  assign bus.dm_mask  = (mem_access && we_q) ? mask_q : '0;
  assign bus.dm_addr  = addr_q;
  assign bus.dm_wdata = wdata_q;

  assign bus.rvalid0 = (state == RESP) && !owner;
  assign bus.rvalid1 = (state == RESP) && owner;
  assign bus.rdata0  = bus.rvalid0 ? rdata_q : '0;
  assign bus.rdata1  = bus.rvalid1 ? rdata_q : '0;
  assign bus.err0    = bus.rvalid0 && err_q;
  assign bus.err1    = bus.rvalid1 && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (gnt0 || gnt1) begin
            state   <= ACCESS;
            owner   <= gnt1;
            we_q    <= gnt1 ? bus.we1    : bus.we0;
            addr_q  <= gnt1 ? bus.addr1  : bus.addr0;
            wdata_q <= gnt1 ? bus.wdata1 : bus.wdata0;
            mask_q  <= gnt1 ? bus.mask1  : bus.mask0;
            if (gnt0 && bus.req1) begin
              if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state   <= RESP;
          err_q   <= oor;
          rdata_q <= (oor || we_q) ? '0 : bus.dm_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a negedge-write memory model behind the strobes.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dm_arbiter_if bus ();

  dm_arbiter #(.DEPTH(1024), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];

  assign bus.dm_rdata = (bus.dm_addr < 32'd1024) ? mem[bus.dm_addr[9:0]] : '0;

  always @(negedge clk) begin
    if (!bus.dm_cs && !bus.dm_wr && bus.dm_addr < 32'd1024) begin
      for (int b = 0; b < 4; b++)
        if (bus.dm_mask[b]) mem[bus.dm_addr[9:0]][b*8 +: 8] <= bus.dm_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.mask0 = m;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.mask1 = m;
    end
  endtask

  task automatic xfer(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, output logic [31:0] rd, output logic e,
                      output logic cs_a);
    int n = 0;
    drive(p, 1'b1, we, a, wd, m);
    #1;
    while (!(p == 1 ? bus.gnt1 : bus.gnt0) && n < 20) begin
      tick();
      n++;
    end
    chk("grant_timeout", 32'(n < 20), 32'd1);
    tick();
    cs_a = bus.dm_cs;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    tick();
    chk("rvalid_owner", 32'(p == 1 ? bus.rvalid1 : bus.rvalid0), 32'd1);
    chk("rvalid_other", 32'(p == 1 ? bus.rvalid0 : bus.rvalid1), 32'd0);
    rd = (p == 1) ? bus.rdata1 : bus.rdata0;
    e  = (p == 1) ? bus.err1 : bus.err0;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic        e, cs_a;
    int          n;
    int          exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    chk("rst_cs", 32'(bus.dm_cs), 32'd1);
    chk("rst_wr", 32'(bus.dm_wr), 32'd1);
    chk("rst_mask", 32'(bus.dm_mask), 32'd0);
    chk("rst_addr", bus.dm_addr, 32'd0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}), 32'd0);
    rst = 1'b0;
    tick();

    // Port-0 full write, stepped cycle by cycle
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'b1111);
    #1;
    chk("w5_gnt0", 32'(bus.gnt0), 32'd1);
    chk("w5_gnt1", 32'(bus.gnt1), 32'd0);
    tick();
    bus.req0 = 1'b0;
    chk("w5_cs", 32'(bus.dm_cs), 32'd0);
    chk("w5_wr", 32'(bus.dm_wr), 32'd0);
    chk("w5_mask", 32'(bus.dm_mask), 32'hF);
    chk("w5_addr", bus.dm_addr, 32'd5);
    chk("w5_wdata", bus.dm_wdata, 32'hDEADBEEF);
    chk("w5_rv_early", 32'(bus.rvalid0), 32'd0);
    tick();
    chk("w5_cs_done", 32'(bus.dm_cs), 32'd1);
    chk("w5_wr_done", 32'(bus.dm_wr), 32'd1);
    chk("w5_rvalid", 32'(bus.rvalid0), 32'd1);
    chk("w5_err", 32'(bus.err0), 32'd0);
    chk("w5_rdata", bus.rdata0, 32'd0);
    tick();
    chk("w5_rv_drop", 32'(bus.rvalid0), 32'd0);
    xfer(0, 1'b0, 32'd5, '0, 4'hF, rd, e, cs_a);
    chk("r5_data", rd, 32'hDEADBEEF);
    chk("r5_cs", 32'(cs_a), 32'd0);

    // Partial-mask merge, then an all-zero mask write that must change nothing
    xfer(0, 1'b1, 32'd9, 32'hAAAAAAAA, 4'b1111, rd, e, cs_a);
    xfer(0, 1'b1, 32'd9, 32'h11223344, 4'b0101, rd, e, cs_a);
    xfer(0, 1'b0, 32'd9, '0, 4'b1111, rd, e, cs_a);
    chk("merge_data", rd, 32'hAA22AA44);
    xfer(0, 1'b1, 32'd9, 32'hFFFFFFFF, 4'b0000, rd, e, cs_a);
    chk("mask0_ack_err", 32'(e), 32'd0);
    xfer(1, 1'b0, 32'd9, '0, 4'b0000, rd, e, cs_a);
    chk("mask0_p1_data", rd, 32'hAA22AA44);

    // Both ports held: starvation limit forces every fifth grant to port 1
    drive(0, 1'b1, 1'b0, 32'd5, '0, '0);
    drive(1, 1'b1, 1'b0, 32'd9, '0, '0);
    #1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!(bus.gnt0 || bus.gnt1) && n < 8) begin
        tick();
        n++;
      end
      chk("starve_timeout", 32'(n < 8), 32'd1);
      chk($sformatf("starve_grant%0d", i), 32'(bus.gnt1), 32'(exp_seq[i]));
      tick();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick(); tick();

    // Out-of-range read from port 1
    xfer(1, 1'b0, 32'd1024, '0, 4'hF, rd, e, cs_a);
    chk("oor_cs", 32'(cs_a), 32'd1);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rdata", rd, 32'd0);

    // Reset arriving inside ACCESS before the write's falling edge
    xfer(0, 1'b1, 32'd7, 32'h12345678, 4'hF, rd, e, cs_a);
    drive(0, 1'b1, 1'b1, 32'd7, 32'h0BADF00D, 4'hF);
    tick();
    chk("mid_cs_pre", 32'(bus.dm_cs), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_cs", 32'(bus.dm_cs), 32'd1);
    chk("mid_wr", 32'(bus.dm_wr), 32'd1);
    chk("mid_mask", 32'(bus.dm_mask), 32'd0);
    chk("mid_addr", bus.dm_addr, 32'd0);
    chk("mid_wdata", bus.dm_wdata, 32'd0);
    chk("mid_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
    bus.req0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    xfer(0, 1'b0, 32'd7, '0, 4'hF, rd, e, cs_a);
    chk("mid_mem7", rd, 32'h12345678);

    // Back-to-back reads, each new request raised in the previous RESP cycle
    xfer(0, 1'b1, 32'd0, 32'hA0A0A0A0, 4'hF, rd, e, cs_a);
    xfer(0, 1'b1, 32'd1, 32'hB1B1B1B1, 4'hF, rd, e, cs_a);
    xfer(0, 1'b1, 32'd2, 32'hC2C2C2C2, 4'hF, rd, e, cs_a);
    drive(0, 1'b1, 1'b0, 32'd0, '0, '0);
    #1;
    chk("b2b_gnt_a", 32'(bus.gnt0), 32'd1);
    tick();
    bus.req0 = 1'b0;
    chk("b2b_gap_a", 32'(bus.rvalid0), 32'd0);
    tick();
    chk("b2b_rv_a", 32'(bus.rvalid0), 32'd1);
    chk("b2b_data_a", bus.rdata0, 32'hA0A0A0A0);
    drive(0, 1'b1, 1'b0, 32'd1, '0, '0);
    #1;
    chk("b2b_gnt_b", 32'(bus.gnt0), 32'd1);
    tick();
    bus.req0 = 1'b0;
    chk("b2b_gap_b", 32'(bus.rvalid0), 32'd0);
    tick();
    chk("b2b_rv_b", 32'(bus.rvalid0), 32'd1);
    chk("b2b_data_b", bus.rdata0, 32'hB1B1B1B1);
    drive(0, 1'b1, 1'b0, 32'd2, '0, '0);
    #1;
    chk("b2b_gnt_c", 32'(bus.gnt0), 32'd1);
    tick();
    bus.req0 = 1'b0;
    chk("b2b_gap_c", 32'(bus.rvalid0), 32'd0);
    tick();
    chk("b2b_rv_c", 32'(bus.rvalid0), 32'd1);
    chk("b2b_data_c", bus.rdata0, 32'hC2C2C2C2);
    tick();
    chk("b2b_idle", 32'(bus.rvalid0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
